// File: rtl/polyvecl_add_seq_if.sv
// Bus bundle for the PolyVecL addition sequencer: start/busy/done control,
// the shared u/v read port and the w write port.
interface polyvecl_add_seq_if #(
    parameter int LANES   = 4,
    parameter int COEFF_W = 32,
    parameter int AW      = 9
);
    logic                       start;
    logic                       busy;
    logic                       done;
    logic                       rd_en;
    logic [AW-1:0]              rd_addr;
    logic [LANES*COEFF_W-1:0]   u_rdata;
    logic [LANES*COEFF_W-1:0]   v_rdata;
    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [LANES*COEFF_W-1:0]   wr_data;

    // Sequencer side
    modport slave (
        input  start, u_rdata, v_rdata,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    // Controller / memory side
    modport master (
        output start, u_rdata, v_rdata,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/polyvecl_add_seq.sv
// Time-multiplexed PolyVecL adder: streams L*N/LANES coefficient groups of u
// and v from memory, adds them lane-wise (wrapping mod 2^COEFF_W) and writes
// each result group to the w memory two cycles after its read strobe.
module polyvecl_add_seq #(
    parameter int L       = 5,
    parameter int N       = 256,
    parameter int COEFF_W = 32,
    parameter int LANES   = 4,
    parameter int AW      = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    polyvecl_add_seq_if.slave    bus
);
    localparam int          G        = L * N / LANES;
    localparam logic [AW-1:0] LAST_GRP = AW'(G - 1);
    localparam int          DW       = LANES * COEFF_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    // Read-return stage: valid flag and group address of data on u/v_rdata
    logic            rd_vld_q;
    logic [AW-1:0]   rd_tag_q;
    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    // State and control-output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= {AW{1'b0}};
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Next-state and next-output logic; outputs are registered so each
    // decision here becomes visible in the following cycle
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = {AW{1'b0}};
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_RUN: begin
                // Current cycle issues rd_addr_q; stop after the last group
                if (rd_addr_q == LAST_GRP) begin
                    state_d   = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (wr_en_q && (wr_addr_q == LAST_GRP)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Lane-wise wrapping adders on the returned read data
    always_comb begin
        wr_data_d = {DW{1'b0}};
        for (int j = 0; j < LANES; j++) begin
            wr_data_d[j*COEFF_W +: COEFF_W] = bus.u_rdata[j*COEFF_W +: COEFF_W]
                                            + bus.v_rdata[j*COEFF_W +: COEFF_W];
        end
    end

    // Read-return and write pipeline; addresses and data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_tag_q  <= {AW{1'b0}};
            wr_en_q   <= 1'b0;
            wr_addr_q <= {AW{1'b0}};
            wr_data_q <= {DW{1'b0}};
        end else begin
            rd_vld_q <= rd_en_q;
            rd_tag_q <= rd_addr_q;
            wr_en_q  <= rd_vld_q;
            if (rd_vld_q) begin
                wr_addr_q <= rd_tag_q;
                wr_data_q <= wr_data_d;
            end else begin
                wr_addr_q <= wr_addr_q;
                wr_data_q <= wr_data_q;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule
